fifo_stream_drain: RTL and testbench
====================================

FIFO_STREAM_DRAIN -- requirements
Module: fifo_stream_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO words and stream data.
REQ-002 Parameter PKT_LEN, default 4, words per packet; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  request to stream; sampled every cycle.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_data  input  DATA_WIDTH  upstream FIFO head word, valid combinationally while fifo_empty=0.
REQ-008 fifo_cs  output  1  FIFO chip select; equals fifo_rd_en.
REQ-009 fifo_rd_en  output  1  pop strobe; the FIFO advances at the same edge.
REQ-010 m_valid  output  1  stream beat valid.
REQ-011 m_ready  input  1  stream sink ready.
REQ-012 m_data  output  DATA_WIDTH  stream beat data.
REQ-013 m_last  output  1  final beat of a packet.
REQ-014 pkt_count  output  16  count of completed packets.
REQ-015 busy  output  1  high when state!=IDLE or the buffer is non-empty.

Function
REQ-016 The block SHALL hold a 2-entry in-order output buffer with occupancy occ in 0..2; each entry stores {last, data}.
REQ-017 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-018 Pop condition: fifo_rd_en = (state==RUN or state==FINISH) and !fifo_empty and occ<2; it SHALL NOT depend combinationally on m_ready.
REQ-019 On a pop, fifo_data SHALL be written into the buffer at that edge with last=(word_idx==PKT_LEN-1).
REQ-020 word_idx SHALL increment on each pop and wrap from PKT_LEN-1 to 0.
REQ-021 m_valid = (occ!=0); m_data/m_last SHALL come from the oldest entry.
REQ-022 A beat is accepted when m_valid && m_ready; simultaneous pop and accept SHALL leave occ unchanged and preserve order.
REQ-023 m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 Steady state with m_ready=1 and FIFO non-empty SHALL sustain one beat per cycle.
REQ-025 IDLE->RUN when enable=1; in IDLE no pops occur.
REQ-026 RUN->IDLE when enable=0 and word_idx==0 (no pop that cycle).
REQ-027 RUN->FINISH when enable=0 and word_idx!=0; a pop still occurs in that cycle if the pop condition holds.
REQ-028 In FINISH, pops SHALL continue regardless of enable until the pop with last=1, then FINISH->IDLE; a packet is never truncated.
REQ-029 The FSM SHALL go from FINISH to RUN when the closing pop occurs with enable=1.
REQ-030 An empty FIFO in RUN/FINISH SHALL stall popping without a state change; m_valid drops once the buffer drains.
REQ-031 pkt_count SHALL increment by 1 on each accepted beat with m_last=1 and wrap from 0xFFFF to 0.
REQ-032 Buffered words SHALL continue to drain in IDLE.

Reset
REQ-033 With reset=1 at an edge: state=IDLE, occ=0, word_idx=0, pkt_count=0.
REQ-034 During and after reset: m_valid=0, fifo_rd_en=0, fifo_cs=0, busy=0; m_data/m_last are don't-care while m_valid=0.
REQ-035 Reset mid-packet SHALL discard the buffered words and the partial packet; no beat SHALL be emitted until a new pop occurs.

Verification
REQ-036 FIFO holds 8 words 0x10..0x17, enable=1, m_ready=1, PKT_LEN=4 -> 8 consecutive beats 0x10..0x17, m_last on 0x13 and 0x17, pkt_count=2, idle FIFO afterward.
REQ-037 enable dropped after 2 pops of a packet -> exactly 2 more pops, last beat carries m_last, FSM returns to IDLE, no further fifo_rd_en.
REQ-038 m_ready=0 for 5 cycles while streaming -> occ saturates at 2, fifo_rd_en=0, m_data stable; on release order is preserved with no loss or duplication.
REQ-039 FIFO empties mid-packet for 3 cycles -> m_valid gaps, word_idx preserved, m_last lands on the 4th word after refill.
REQ-040 reset asserted with occ=2 mid-packet -> next cycle m_valid=0, pkt_count=0, busy=0; the next packet's first word has m_last=0.
REQ-041 m_ready random 50% over 1000 words -> output sequence equals input sequence, m_last every 4th beat, pkt_count=250.

Source files
------------

// File: rtl/fifo_stream_drain_if.sv
// Bundle of the upstream FIFO pop port and the downstream valid/ready stream.
// Stream handshake: a beat transfers on a rising edge where m_valid && m_ready; once m_valid
// is raised, m_data/m_last hold until that transfer, and m_valid never waits on m_ready.
interface fifo_stream_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_cs;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_cs,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_cs,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains an upstream FIFO into a packetised valid/ready stream through a 2-entry skid buffer;
// packets of PKT_LEN words are never truncated when enable drops mid-packet.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    fifo_stream_drain_if.master bus,
    output logic [15:0] pkt_count,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    localparam int IDX_W = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [1:0]          occ;
    logic [IDX_W-1:0]    word_idx;
    logic [DATA_WIDTH:0] entry0;
    logic [DATA_WIDTH:0] entry1;
    logic                pop_allowed;
    logic                pop;
    logic                pop_last;
    logic                accept;

    // Popping depends only on state, enable and buffer room, never on m_ready.
    always_comb begin
        pop_allowed = 1'b0;
        case (state)
            S_RUN:    pop_allowed = enable || (word_idx != '0);
            S_FINISH: pop_allowed = 1'b1;
            default:  pop_allowed = 1'b0;
        endcase
        pop      = pop_allowed && !bus.fifo_empty && (occ != 2'd2) && !reset;
        pop_last = (word_idx == LAST_IDX);
        accept   = bus.m_valid && bus.m_ready;
    end

    assign bus.fifo_rd_en = pop;
    assign bus.fifo_cs    = pop;
    assign bus.m_valid    = (occ != 2'd0) && !reset;
    assign bus.m_data     = entry0[DATA_WIDTH-1:0];
    assign bus.m_last     = entry0[DATA_WIDTH];
    assign busy           = ((state != S_IDLE) || (occ != 2'd0)) && !reset;
    assign state_dbg      = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_RUN;
            end
            S_RUN: begin
                // A packet already open keeps draining; a pop that closes it ends the run.
                if (!enable) begin
                    if (word_idx == '0 || (pop && pop_last)) state_nxt = S_IDLE;
                    else                                     state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                if (pop && pop_last) state_nxt = enable ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            occ       <= 2'd0;
            word_idx  <= '0;
            pkt_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (pop) word_idx <= pop_last ? '0 : word_idx + 1'b1;
            if (accept && bus.m_last) pkt_count <= pkt_count + 16'd1;
            case ({pop, accept})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Buffer payload needs no reset: occ alone decides what is visible.
    always_ff @(posedge clk) begin
        case ({pop, accept})
            2'b10: begin
                if (occ == 2'd0) entry0 <= {pop_last, bus.fifo_data};
                else             entry1 <= {pop_last, bus.fifo_data};
            end
            2'b01: entry0 <= entry1;
            2'b11: begin
                if (occ == 2'd1) begin
                    entry0 <= {pop_last, bus.fifo_data};
                end else begin
                    entry0 <= entry1;
                    entry1 <= {pop_last, bus.fifo_data};
                end
            end
            default: begin
                entry0 <= entry0;
                entry1 <= entry1;
            end
        endcase
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Scoreboard bench: an emulated upstream FIFO feeds the block; every observed pop pushes the
// expected {last, data} beat, and a monitor checks each accepted beat against that queue.
module tb_fifo_stream_drain;
    localparam int DW = 32;
    localparam int PL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] pkt_count;
    logic        busy;
    logic [1:0]  state_dbg;

    fifo_stream_drain_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .pkt_count (pkt_count),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_q[$];
    logic [DW:0]   exp_q[$];
    int            beat_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            model_idx = 0;
    int            exp_pkt = 0;
    int            pop_cnt = 0;
    int            beat_cnt = 0;
    int            last_cnt = 0;
    int            cyc = 0;
    logic          hold_prev = 1'b0;
    logic [DW:0]   held = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Positions the caller after the monitor has finished with the current cycle.
    task automatic sample();
        @(negedge clk);
        #4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        model_idx = 0;
        exp_pkt   = 0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic run_until_drained(input string name, input int budget, input bit rand_ready);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got src=%0d exp=%0d want 0", name, src_q.size(), exp_q.size());
        end
        bus.m_ready = 1'b1;
    endtask

    // Upstream FIFO emulation: head word is presented while non-empty.
    always @(negedge clk) begin
        bus.fifo_empty = (src_q.size() == 0);
        bus.fifo_data  = (src_q.size() == 0) ? '0 : src_q[0];
    end

    // Monitor: inputs are stable here, so rd_en and accept reflect the coming edge.
    always @(negedge clk) begin
        logic [DW:0]   e;
        logic [DW-1:0] w;
        #3;
        cyc++;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            check("cs_eq_rd_en", 64'(bus.fifo_cs), 64'(bus.fifo_rd_en));
            check("valid_vs_model", 64'(bus.m_valid), 64'(exp_q.size() != 0));
            check("occ_le_2", 64'(exp_q.size() <= 2), 64'(1));
            if (hold_prev)
                check("hold_stable", {31'd0, bus.m_valid, bus.m_last, bus.m_data}, {31'd0, 1'b1, held});
            if (bus.m_valid && bus.m_ready) begin
                beat_cnt++;
                beat_cyc.push_back(cyc);
                if (bus.m_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want no beat", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(bus.m_data), 64'(e[DW-1:0]));
                    check("beat_last", 64'(bus.m_last), 64'(e[DW]));
                    if (e[DW]) exp_pkt++;
                end
            end
            if (bus.fifo_rd_en) begin
                if (src_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_on_empty: got rd_en=1 want 0");
                end else begin
                    w = src_q.pop_front();
                    exp_q.push_back({model_idx == PL - 1, w});
                    model_idx = (model_idx + 1) % PL;
                    pop_cnt++;
                end
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            held      = {bus.m_last, bus.m_data};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_pop;
        int base_beat;
        int base_last;
        int n;

        // Reset with enable high and data waiting: nothing may pop or stream.
        reset       = 1'b1;
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        src_q.push_back(32'h99);
        step(3);
        sample();
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
        check("rst_cs", 64'(bus.fifo_cs), 64'(0));
        check("rst_valid", 64'(bus.m_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        enable = 1'b0;
        src_q.delete();
        step(1);
        reset = 1'b0;
        sample();
        check("post_rst_pkt", 64'(pkt_count), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_valid", 64'(bus.m_valid), 64'(0));

        // Eight words, free-flowing sink: back-to-back beats, two packets.
        for (int i = 0; i < 8; i++) src_q.push_back(32'h10 + i);
        beat_cyc.delete();
        base_last = last_cnt;
        @(negedge clk);
        enable = 1'b1;
        run_until_drained("t_burst", 100, 1'b0);
        step(2);
        check("burst_beats", 64'(beat_cyc.size()), 64'(8));
        if (beat_cyc.size() == 8)
            check("burst_back_to_back", 64'(beat_cyc[7] - beat_cyc[0]), 64'(7));
        check("burst_lasts", 64'(last_cnt - base_last), 64'(2));
        check("burst_pkt", 64'(pkt_count), 64'(2));
        enable = 1'b0;
        sample();
        sample();
        check("burst_idle_busy", 64'(busy), 64'(0));
        check("burst_idle_rd_en", 64'(bus.fifo_rd_en), 64'(0));

        // Drop enable after two pops: the open packet still completes, then nothing more.
        for (int i = 0; i < 10; i++) src_q.push_back(32'h20 + i);
        base_pop = pop_cnt;
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (pop_cnt - base_pop < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drop_reached_two", 64'(pop_cnt - base_pop >= 2), 64'(1));
        enable = 1'b0;
        step(12);
        check("drop_pops", 64'(pop_cnt - base_pop), 64'(4));
        check("drop_src_left", 64'(src_q.size()), 64'(6));
        check("drop_drained", 64'(exp_q.size()), 64'(0));
        check("drop_busy", 64'(busy), 64'(0));
        check("drop_pkt", 64'(pkt_count), 64'(3));
        sample();
        check("drop_no_rd_en", 64'(bus.fifo_rd_en), 64'(0));
        src_q.delete();

        // Sink stalls five cycles: buffer fills, popping stops, data holds.
        for (int i = 0; i < 12; i++) src_q.push_back(32'h30 + i);
        base_beat = beat_cnt;
        @(negedge clk);
        enable = 1'b1;
        step(4);
        bus.m_ready = 1'b0;
        step(4);
        #4;
        check("stall_rd_en", 64'(bus.fifo_rd_en), 64'(0));
        check("stall_occ", 64'(exp_q.size()), 64'(2));
        check("stall_valid", 64'(bus.m_valid), 64'(1));
        @(negedge clk);
        bus.m_ready = 1'b1;
        run_until_drained("t_stall", 200, 1'b0);
        enable = 1'b0;
        step(3);
        check("stall_beats", 64'(beat_cnt - base_beat), 64'(12));
        check("stall_pkt", 64'(pkt_count), 64'(exp_pkt));
        check("stall_busy", 64'(busy), 64'(0));

        // Source runs dry mid-packet: gap on the stream, packet position kept.
        src_q.push_back(32'h40);
        src_q.push_back(32'h41);
        base_last = last_cnt;
        @(negedge clk);
        enable = 1'b1;
        run_until_drained("t_gap_a", 50, 1'b0);
        step(3);
        #4;
        check("gap_valid", 64'(bus.m_valid), 64'(0));
        check("gap_busy", 64'(busy), 64'(1));
        for (int i = 2; i < 8; i++) src_q.push_back(32'h40 + i);
        run_until_drained("t_gap_b", 100, 1'b0);
        enable = 1'b0;
        step(3);
        check("gap_lasts", 64'(last_cnt - base_last), 64'(2));
        check("gap_pkt", 64'(pkt_count), 64'(exp_pkt));

        // Reset with a full buffer mid-packet: buffered words and partial packet are dropped.
        for (int i = 0; i < 10; i++) src_q.push_back(32'h50 + i);
        bus.m_ready = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        step(5);
        #4;
        check("pre_rst_occ", 64'(exp_q.size()), 64'(2));
        do_reset();
        #4;
        check("mid_rst_valid", 64'(bus.m_valid), 64'(0));
        check("mid_rst_pkt", 64'(pkt_count), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        base_beat = beat_cnt;
        @(negedge clk);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        run_until_drained("t_rst", 100, 1'b0);
        enable = 1'b0;
        step(3);
        check("rst_after_beats", 64'(beat_cnt - base_beat), 64'(8));
        check("rst_after_pkt", 64'(pkt_count), 64'(2));

        // Long random run with a 50% sink.
        do_reset();
        for (int i = 0; i < 1000; i++) src_q.push_back($urandom);
        base_beat = beat_cnt;
        base_last = last_cnt;
        @(negedge clk);
        enable = 1'b1;
        run_until_drained("t_rand", 8000, 1'b1);
        enable = 1'b0;
        step(3);
        check("rand_beats", 64'(beat_cnt - base_beat), 64'(1000));
        check("rand_lasts", 64'(last_cnt - base_last), 64'(250));
        check("rand_pkt", 64'(pkt_count), 64'(250));
        check("rand_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
